// File: rtl/sram_pkg.sv
// Shared constants and helpers for the pipelined cache data/tag array.
// The DEF_* constants describe the default geometry; instances derive their own via the functions.
package sram_pkg;

    localparam int unsigned DEF_WIDTH           = 64;
    localparam int unsigned DEF_LOG_DEPTH       = 9;
    localparam int unsigned DEF_LOG_LINE_OFFSET = 3;
    localparam int unsigned DEF_WORDS           = 1 << DEF_LOG_LINE_OFFSET;
    localparam int unsigned DEF_WORD_W          = DEF_WIDTH >> DEF_LOG_LINE_OFFSET;
    localparam int unsigned DEF_DEPTH           = 1 << DEF_LOG_DEPTH;

    // Upper bounds for the width-generic merge helper.
    localparam int unsigned MAX_WIDTH  = 512;
    localparam int unsigned MAX_WORDS  = 64;
    localparam int unsigned MAX_WIDX_W = 6;

    function automatic int unsigned words_of(input int unsigned log_line_offset);
        return 1 << log_line_offset;
    endfunction

    function automatic int unsigned word_w_of(input int unsigned width, input int unsigned log_line_offset);
        return width >> log_line_offset;
    endfunction

    function automatic int unsigned depth_of(input int unsigned log_depth);
        return 1 << log_depth;
    endfunction

    // Lines are zero-extended to MAX_WIDTH by the caller; word_w selects the word granularity.
    function automatic logic [MAX_WIDTH-1:0] word_merge(
        input logic [MAX_WIDTH-1:0] old_line,
        input logic [MAX_WIDTH-1:0] new_line,
        input logic [MAX_WORDS-1:0] mask,
        input int unsigned          word_w
    );
        logic [MAX_WIDTH-1:0]  merged;
        logic [MAX_WIDX_W-1:0] widx;
        merged = old_line;
        for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
            if (word_w != 0 && (b / word_w) < MAX_WORDS) begin
                widx = MAX_WIDX_W'(b / word_w);
                if (mask[widx]) begin
                    merged[b] = new_line[b];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// DELAY-stage valid/data/tag shift register with a shared advance enable.
// Reset clears every stage asynchronously, so in-flight reads vanish without a response.
module sram_read_pipe #(
    parameter int unsigned DELAY  = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic [DELAY-1:0]             valid_q, valid_d;
    logic [DELAY-1:0][DATA_W-1:0] data_q,  data_d;
    logic [DELAY-1:0][TAG_W-1:0]  tag_q,   tag_d;

    // The whole pipe moves as one unit; bubbles are never squeezed out during a stall.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (advance_i) begin
            valid_d[0] = in_valid_i;
            data_d[0]  = in_data_i;
            tag_d[0]   = in_tag_i;
            for (int unsigned k = 1; k < DELAY; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q[DELAY-1];
    assign data_o  = data_q[DELAY-1];
    assign tag_o   = tag_q[DELAY-1];

endmodule

// File: rtl/pipelined_sram.sv
// Cache data/tag array: one masked write port and one fully pipelined, tagged read port
// with fixed latency DELAY and response back-pressure.
module pipelined_sram
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned LOG_DEPTH       = 9,
    parameter int unsigned LOG_LINE_OFFSET = 3,
    parameter int unsigned DELAY           = 2,
    parameter int unsigned TAG_W           = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            readReq,
    output logic                            readReady,
    input  logic [LOG_DEPTH-1:0]            readAddr,
    input  logic [TAG_W-1:0]                readTag,
    output logic                            respValid,
    input  logic                            respReady,
    output logic [WIDTH-1:0]                readData,
    output logic [TAG_W-1:0]                respTag,
    input  logic                            writeEnable,
    input  logic [LOG_DEPTH-1:0]            writeAddr,
    input  logic [(1<<LOG_LINE_OFFSET)-1:0] writeMask,
    input  logic [WIDTH-1:0]                writeData
);

    localparam int unsigned WORDS  = words_of(LOG_LINE_OFFSET);
    localparam int unsigned WORD_W = word_w_of(WIDTH, LOG_LINE_OFFSET);
    localparam int unsigned DEPTH  = depth_of(LOG_DEPTH);

    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $fatal(1, "pipelined_sram: DELAY=%0d outside 1..16", DELAY);
    end else if (WIDTH % WORDS != 0) begin : g_bad_width
        $fatal(1, "pipelined_sram: WIDTH=%0d not divisible by %0d words", WIDTH, WORDS);
    end else if (WIDTH > MAX_WIDTH || WORDS > MAX_WORDS) begin : g_too_wide
        $fatal(1, "pipelined_sram: WIDTH=%0d / WORDS=%0d exceed merge helper limits", WIDTH, WORDS);
    end else begin : g_info
        $info("pipelined_sram: %0d lines x %0d bits, read latency %0d", DEPTH, WIDTH, DELAY);
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             advance;
    logic [WIDTH-1:0] rd_line_d;
    logic [WIDTH-1:0] wr_line_d;

    logic [MAX_WIDTH-1:0] old_ext, new_ext, merged_ext;
    logic [MAX_WORDS-1:0] mask_ext;

    assign advance   = !respValid || respReady;
    assign readReady = advance;

    // Nonblocking memory update gives read-before-write for a same-edge read of the written line.
    assign rd_line_d = mem_q[readAddr];

    always_comb begin
        old_ext                 = '0;
        new_ext                 = '0;
        mask_ext                = '0;
        old_ext[WIDTH-1:0]      = mem_q[writeAddr];
        new_ext[WIDTH-1:0]      = writeData;
        mask_ext[WORDS-1:0]     = writeMask;
        merged_ext              = word_merge(old_ext, new_ext, mask_ext, WORD_W);
        wr_line_d               = merged_ext[WIDTH-1:0];
    end

    // Array contents are deliberately not reset; reset only blocks the write on that edge.
    always_ff @(posedge clk) begin
        if (!reset && writeEnable) begin
            mem_q[writeAddr] <= wr_line_d;
        end
    end

    sram_read_pipe #(
        .DELAY  (DELAY),
        .DATA_W (WIDTH),
        .TAG_W  (TAG_W)
    ) u_read_pipe (
        .clk        (clk),
        .rst        (reset),
        .advance_i  (advance),
        .in_valid_i (readReq),
        .in_data_i  (rd_line_d),
        .in_tag_i   (readTag),
        .valid_o    (respValid),
        .data_o     (readData),
        .tag_o      (respTag)
    );

endmodule

// File: tb/tb_pipelined_sram.sv
// Self-checking bench for pipelined_sram (DELAY=2): table-driven cycles plus directed sequences,
// with a scoreboard queue filled at read acceptance and drained at response handshake.
module tb_pipelined_sram;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned LD    = 9;
    localparam int unsigned TW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             readReq;
    logic             readReady;
    logic [LD-1:0]    readAddr;
    logic [TW-1:0]    readTag;
    logic             respValid;
    logic             respReady;
    logic [WIDTH-1:0] readData;
    logic [TW-1:0]    respTag;
    logic             writeEnable;
    logic [LD-1:0]    writeAddr;
    logic [7:0]       writeMask;
    logic [WIDTH-1:0] writeData;

    pipelined_sram #(
        .WIDTH           (WIDTH),
        .LOG_DEPTH       (LD),
        .LOG_LINE_OFFSET (3),
        .DELAY           (2),
        .TAG_W           (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .readReq     (readReq),
        .readReady   (readReady),
        .readAddr    (readAddr),
        .readTag     (readTag),
        .respValid   (respValid),
        .respReady   (respReady),
        .readData    (readData),
        .respTag     (respTag),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .writeMask   (writeMask),
        .writeData   (writeData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TW-1:0]    tag;
    } resp_t;

    typedef struct {
        logic             we;
        logic [LD-1:0]    waddr;
        logic [WIDTH-1:0] wdata;
        logic             re;
        logic [LD-1:0]    raddr;
        logic [TW-1:0]    rtag;
        logic             rr;
        logic             exp_rv;
        logic             exp_rdy;
    } vec_t;

    resp_t            sb[$];
    logic [WIDTH-1:0] mdl [1<<LD];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             stall_q = 1'b0;
    logic [WIDTH-1:0] hold_data;
    logic [TW-1:0]    hold_tag;
    vec_t             tbl [16];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        readReq     = 1'b0;
        readAddr    = '0;
        readTag     = '0;
        respReady   = 1'b1;
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeMask   = '0;
        writeData   = '0;
    endtask

    // One clock with the current inputs; called at the negedge, returns at the next negedge.
    task automatic step();
        #1;
        if (respValid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_resp: respValid=1 tag=%0d, required no response", respTag);
            end else begin
                chk("resp_data", readData, sb[0].data);
                chk("resp_tag", WIDTH'(respTag), WIDTH'(sb[0].tag));
                if (respReady) sb.delete(0);
            end
        end
        if (stall_q) begin
            chk("stall_data", readData, hold_data);
            chk("stall_tag", WIDTH'(respTag), WIDTH'(hold_tag));
        end
        stall_q   = respValid && !respReady;
        hold_data = readData;
        hold_tag  = respTag;
        if (readReq && readReady) sb.push_back('{mdl[readAddr], readTag});
        if (writeEnable && !reset) begin
            for (int i = 0; i < 8; i++)
                if (writeMask[i]) mdl[writeAddr][i*8 +: 8] = writeData[i*8 +: 8];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [LD-1:0] a, input logic [WIDTH-1:0] d, input logic [7:0] m);
        writeEnable = 1'b1;
        writeAddr   = a;
        writeData   = d;
        writeMask   = m;
        step();
        writeEnable = 1'b0;
        writeMask   = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 12 && sb.size() != 0; i++) step();
        chk("drain_empty", WIDTH'(sb.size()), '0);
    endtask

    initial begin
        for (int i = 0; i < (1 << LD); i++) mdl[i] = '0;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_respValid", WIDTH'(respValid), '0);
        chk("rst_readData", readData, '0);
        chk("rst_respTag", WIDTH'(respTag), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_readReady", WIDTH'(readReady), WIDTH'(1'b1));
        @(negedge clk);

        // Latency: line 5 full write, then one read with tag 3.
        wr(9'd5, {16{4'hA}}, 8'hFF);
        readReq  = 1'b1;
        readAddr = 9'd5;
        readTag  = 4'd3;
        step();
        readReq = 1'b0;
        #1;
        chk("lat_not_early", WIDTH'(respValid), '0);
        step();
        #1;
        chk("lat_valid", WIDTH'(respValid), WIDTH'(1'b1));
        chk("lat_data", readData, {16{4'hA}});
        chk("lat_tag", WIDTH'(respTag), WIDTH'(4'd3));
        drain();

        // Table: back-to-back reads, then a 3-cycle stall with a pending request and a write under it.
        for (int k = 1; k <= 4; k++) wr(LD'(k), {8{8'(k * 8'h11)}}, 8'hFF);
        tbl[0]  = '{1'b0, 9'd0, '0,                1'b1, 9'd1, 4'd1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 9'd0, '0,                1'b1, 9'd2, 4'd2, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 9'd0, '0,                1'b1, 9'd3, 4'd3, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 9'd0, '0,                1'b1, 9'd4, 4'd4, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 9'd0, '0,                1'b1, 9'd1, 4'd5, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 9'd0, '0,                1'b1, 9'd2, 4'd6, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 9'd0, '0,                1'b1, 9'd3, 4'd7, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 9'd3, 64'h3C3C_3C3C_3C3C_3C3C, 1'b1, 9'd3, 4'd7, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 9'd0, '0,                1'b1, 9'd3, 4'd7, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 9'd0, '0,                1'b1, 9'd3, 4'd7, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 9'd0, '0,                1'b0, 9'd0, 4'd0, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 16; r++) begin
            writeEnable = tbl[r].we;
            writeAddr   = tbl[r].waddr;
            writeData   = tbl[r].wdata;
            writeMask   = tbl[r].we ? 8'hFF : 8'h00;
            readReq     = tbl[r].re;
            readAddr    = tbl[r].raddr;
            readTag     = tbl[r].rtag;
            respReady   = tbl[r].rr;
            #1;
            chk($sformatf("tbl%0d_respValid", r), WIDTH'(respValid), WIDTH'(tbl[r].exp_rv));
            chk($sformatf("tbl%0d_readReady", r), WIDTH'(readReady), WIDTH'(tbl[r].exp_rdy));
            step();
        end
        drain();

        // Masked write: only word 2 of line 7 becomes all ones; zero mask leaves line 5 untouched.
        wr(9'd7, '0, 8'hFF);
        wr(9'd7, '1, 8'b0000_0100);
        wr(9'd5, 64'h0123_4567_89AB_CDEF, 8'h00);
        readReq  = 1'b1;
        readAddr = 9'd7;
        readTag  = 4'd9;
        step();
        readAddr = 9'd5;
        readTag  = 4'd10;
        step();
        readReq = 1'b0;
        #1;
        chk("mask_word2", readData, 64'h0000_0000_00FF_0000);
        step();
        #1;
        chk("mask_zero_noop", readData, {16{4'hA}});
        drain();

        // Same-edge read and write of line 9: old data first, new data on the following read.
        wr(9'd9, {16{4'h1}}, 8'hFF);
        readReq     = 1'b1;
        readAddr    = 9'd9;
        readTag     = 4'd11;
        writeEnable = 1'b1;
        writeAddr   = 9'd9;
        writeData   = {16{4'h2}};
        writeMask   = 8'hFF;
        step();
        writeEnable = 1'b0;
        readTag     = 4'd12;
        step();
        readReq = 1'b0;
        #1;
        chk("rbw_old", readData, {16{4'h1}});
        step();
        #1;
        chk("rbw_new", readData, {16{4'h2}});
        drain();

        // Reset with reads in flight: outputs clear at once, no stale responses, memory retained.
        readReq  = 1'b1;
        readAddr = 9'd5;
        readTag  = 4'd13;
        step();
        readAddr = 9'd9;
        readTag  = 4'd14;
        step();
        readReq = 1'b0;
        reset   = 1'b1;
        #1;
        chk("mid_rst_respValid", WIDTH'(respValid), '0);
        chk("mid_rst_readData", readData, '0);
        chk("mid_rst_respTag", WIDTH'(respTag), '0);
        sb.delete();
        stall_q     = 1'b0;
        writeEnable = 1'b1;
        writeAddr   = 9'd5;
        writeData   = 64'hDEAD_BEEF_DEAD_BEEF;
        writeMask   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        readReq  = 1'b1;
        readAddr = 9'd5;
        readTag  = 4'd15;
        step();
        readReq = 1'b0;
        step();
        #1;
        chk("post_rst_valid", WIDTH'(respValid), WIDTH'(1'b1));
        chk("post_rst_retained", readData, {16{4'hA}});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
